// File: rtl/uart_rx_framer.sv
// UART receive framer: recovers start/data/stop frames from a serial line,
// samples at bit centre and flags start glitches and bad stop bits.
module uart_rx_framer #(
   parameter int p_CLKS_PER_BIT = 4,
   parameter int p_WIDTH        = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_input,
   output logic [p_WIDTH-1:0] o_data,
   output logic               o_data_ready,
   output logic               o_frame_error,
   output logic               o_busy
);

   localparam int CW = $clog2(p_CLKS_PER_BIT);
   localparam int IW = $clog2(p_WIDTH + 1);
   localparam logic [CW-1:0] HALF     = CW'((p_CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST     = CW'(p_CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(p_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t             state;
   logic               s1, s2;
   logic [CW-1:0]      cnt;
   logic [IW-1:0]      idx;
   logic [p_WIDTH-1:0] shreg;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= IDLE;
         s1            <= 1'b1;
         s2            <= 1'b1;
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         o_data        <= '0;
         o_data_ready  <= 1'b0;
         o_frame_error <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         s1            <= i_input;
         s2            <= s1;
         o_data_ready  <= 1'b0;
         o_frame_error <= 1'b0;
         o_busy        <= 1'b1;
         cnt           <= cnt + 1'b1;
         case (state)
            IDLE: begin
               // busy drops one cycle after returning to IDLE
               o_busy <= ~s2;
               if (!s2) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == HALF) begin
                  cnt <= '0;
                  if (!s2) begin
                     state <= DATA;
                     idx   <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               // clear on each sample so non power-of-two periods wrap correctly
               if (cnt == LAST) begin
                  cnt   <= '0;
                  shreg <= {s2, shreg[p_WIDTH-1:1]};
                  idx   <= idx + 1'b1;
                  if (idx == LAST_IDX) state <= STOP;
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (s2) begin
                     o_data       <= shreg;
                     o_data_ready <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     o_frame_error <= 1'b1;
                     state         <= BRK;
                  end
               end
            end
            BRK: begin
               // wait out a held-low line so it cannot start another frame
               if (s2) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: default instance plus a period sweep.
module tb_uart_rx_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic       line  [4];
   logic [7:0] data  [4];
   logic       ready [4];
   logic       ferr  [4];
   logic       busy  [4];

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         rdy_cnt [4];
   int         err_cnt [4];
   int         rdy_edge[4];
   int         rdy_prev[4];
   int         err_edge[4];
   logic [7:0] rdy_dat [4];
   logic [7:0] rdy_pdat[4];
   int         excl = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         uart_rx_framer #(
            .p_CLKS_PER_BIT((g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 5 : 16),
            .p_WIDTH(8)
         ) dut (
            .i_clk(clk),
            .i_reset(rst),
            .i_input(line[g]),
            .o_data(data[g]),
            .o_data_ready(ready[g]),
            .o_frame_error(ferr[g]),
            .o_busy(busy[g])
         );
      end
   endgenerate

   // pulses registered at edge N are seen here with cyc == N
   always @(negedge clk) begin
      for (int g = 0; g < 4; g++) begin
         if (ready[g] && ferr[g]) excl <= excl + 1;
         if (ready[g]) begin
            rdy_cnt[g]  <= rdy_cnt[g] + 1;
            rdy_prev[g] <= rdy_edge[g];
            rdy_edge[g] <= cyc;
            rdy_pdat[g] <= rdy_dat[g];
            rdy_dat[g]  <= data[g];
         end
         if (ferr[g]) begin
            err_cnt[g]  <= err_cnt[g] + 1;
            err_edge[g] <= cyc;
         end
      end
   end

   function automatic int cpb_of(input int g);
      return (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 5 : 16;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // t0 is the edge at which the start bit is first captured
   task automatic send(input int g, input logic [7:0] d, input logic stop, output int t0);
      int c;
      c = cpb_of(g);
      line[g] = 1'b0;
      t0 = cyc + 1;
      tick(c);
      for (int i = 0; i < 8; i++) begin
         line[g] = d[i];
         tick(c);
      end
      line[g] = stop;
      tick(c);
   endtask

   initial begin
      int         t0;
      logic [7:0] abort_word;

      rst = 1'b1;
      for (int g = 0; g < 4; g++) line[g] = 1'b1;
      tick(3);
      chk("reset_data", 32'(data[0]), 32'h00);
      chk("reset_ready", 32'(ready[0]), 32'h0);
      chk("reset_ferr", 32'(ferr[0]), 32'h0);
      chk("reset_busy", 32'(busy[0]), 32'h0);
      rst = 1'b0;
      tick(4);

      // start glitch: one low cycle
      line[0] = 1'b0;
      tick(1);
      line[0] = 1'b1;
      tick(2);
      chk("glitch_busy_e2", 32'(busy[0]), 32'h1);
      tick(3);
      chk("glitch_busy_e5", 32'(busy[0]), 32'h0);
      tick(4);
      chk("glitch_no_ready", 32'(rdy_cnt[0]), 32'd0);
      chk("glitch_no_ferr", 32'(err_cnt[0]), 32'd0);
      chk("glitch_data", 32'(data[0]), 32'h00);

      // good frame
      send(0, 8'hA5, 1'b1, t0);
      tick(3);
      chk("a5_ready_cnt", 32'(rdy_cnt[0]), 32'd1);
      chk("a5_ready_edge", 32'(rdy_edge[0] - t0), 32'd40);
      chk("a5_data", 32'(data[0]), 32'hA5);
      chk("a5_no_ferr", 32'(err_cnt[0]), 32'd0);
      chk("a5_idle_busy", 32'(busy[0]), 32'h0);

      // framing error followed by a held-low line
      send(0, 8'h3C, 1'b1, t0);
      send(0, 8'h81, 1'b0, t0);
      tick(40);
      chk("fe_err_cnt", 32'(err_cnt[0]), 32'd1);
      chk("fe_err_edge", 32'(err_edge[0] - t0), 32'd40);
      chk("fe_ready_cnt", 32'(rdy_cnt[0]), 32'd2);
      chk("fe_3c_seen", 32'(rdy_dat[0]), 32'h3C);
      chk("fe_data_held", 32'(data[0]), 32'h3C);
      chk("fe_break_busy", 32'(busy[0]), 32'h1);
      line[0] = 1'b1;
      tick(6);
      chk("fe_recover_busy", 32'(busy[0]), 32'h0);
      chk("fe_single_err", 32'(err_cnt[0]), 32'd1);
      send(0, 8'h55, 1'b1, t0);
      tick(3);
      chk("fe_55_data", 32'(data[0]), 32'h55);
      chk("fe_55_ready_cnt", 32'(rdy_cnt[0]), 32'd3);

      // back-to-back frames, no idle gap
      send(0, 8'h00, 1'b1, t0);
      send(0, 8'hFF, 1'b1, t0);
      tick(3);
      chk("b2b_ready_cnt", 32'(rdy_cnt[0]), 32'd5);
      chk("b2b_spacing", 32'(rdy_edge[0] - rdy_prev[0]), 32'd40);
      chk("b2b_first", 32'(rdy_pdat[0]), 32'h00);
      chk("b2b_second", 32'(rdy_dat[0]), 32'hFF);

      // reset during data bit 3 of 0xF0
      abort_word = 8'hF0;
      line[0] = 1'b0;
      tick(4);
      for (int i = 0; i < 3; i++) begin
         line[0] = abort_word[i];
         tick(4);
      end
      line[0] = abort_word[3];
      tick(2);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_data", 32'(data[0]), 32'h00);
      chk("mid_rst_ready", 32'(ready[0]), 32'h0);
      chk("mid_rst_ferr", 32'(ferr[0]), 32'h0);
      chk("mid_rst_busy", 32'(busy[0]), 32'h0);
      line[0] = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(8);
      chk("mid_rst_no_ready", 32'(rdy_cnt[0]), 32'd5);
      chk("mid_rst_no_ferr", 32'(err_cnt[0]), 32'd1);
      send(0, 8'h12, 1'b1, t0);
      tick(3);
      chk("mid_rst_12_data", 32'(data[0]), 32'h12);
      chk("mid_rst_12_cnt", 32'(rdy_cnt[0]), 32'd6);

      // bit-period sweep: L = 3 + (C-1)/2 + 9*C
      for (int g = 1; g < 4; g++) begin
         send(g, 8'h6E, 1'b1, t0);
         tick(4);
         chk($sformatf("sweep%0d_data", cpb_of(g)), 32'(data[g]), 32'h6E);
         chk($sformatf("sweep%0d_edge", cpb_of(g)), 32'(rdy_edge[g] - t0),
             32'(3 + (cpb_of(g) - 1) / 2 + 9 * cpb_of(g)));
         chk($sformatf("sweep%0d_cnt", cpb_of(g)), 32'(rdy_cnt[g]), 32'd1);
         chk($sformatf("sweep%0d_ferr", cpb_of(g)), 32'(err_cnt[g]), 32'd0);
      end

      chk("pulse_exclusive", 32'(excl), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
